// File: rtl/vec_add_seq_if.sv
// Bus bundle for vec_add_seq: job control/status, operand read ports and
// result write port. The slave side is the adder; the master side is the host.
interface vec_add_seq_if #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 10,
   parameter int LEN_W  = 11
);
   // job control
   logic              start;
   logic              abort;
   logic [ADDR_W-1:0] src_a_base;
   logic [ADDR_W-1:0] src_b_base;
   logic [ADDR_W-1:0] dst_base;
   logic [LEN_W-1:0]  len;

   // operand reads (data returns one cycle after rd_en)
   logic              rd_en;
   logic [ADDR_W-1:0] rd_addr_a;
   logic [ADDR_W-1:0] rd_addr_b;
   logic [DATA_W-1:0] rd_data_a;
   logic [DATA_W-1:0] rd_data_b;

   // result writes
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;

   // status
   logic              busy;
   logic              done;
   logic [LEN_W-1:0]  sat_cnt;

   modport slave (
      input  start, abort, src_a_base, src_b_base, dst_base, len,
      input  rd_data_a, rd_data_b,
      output rd_en, rd_addr_a, rd_addr_b,
      output wr_en, wr_addr, wr_data,
      output busy, done, sat_cnt
   );

   modport master (
      output start, abort, src_a_base, src_b_base, dst_base, len,
      output rd_data_a, rd_data_b,
      input  rd_en, rd_addr_a, rd_addr_b,
      input  wr_en, wr_addr, wr_data,
      input  busy, done, sat_cnt
   );
endinterface

// File: rtl/vec_add_seq.sv
// Streaming saturating vector adder: reads A[i] and B[i] from two scratchpad
// ports and writes sat(A[i]+B[i]) to dst+i, one element per cycle.
// Pipeline: cycle t rd_en/addr, t+1 read data + valid, t+2 wr_en/wr_data.
module vec_add_seq #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 10,
   parameter int LEN_W  = 11
) (
   input  logic         clk,
   input  logic         rst_n,
   vec_add_seq_if.slave bus
);

   // vld_pipe[0]: read issued, [1]: read data on the bus, [2]: result on wr_*
   localparam int STAGES = 2;

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FIN} state_t;

   // job configuration captured at an accepted start
   typedef struct packed {
      logic [ADDR_W-1:0] src_a;
      logic [ADDR_W-1:0] src_b;
      logic [ADDR_W-1:0] dst;
      logic [LEN_W-1:0]  len;
   } cfg_t;

   state_t            state_q, state_d;
   cfg_t              cfg_q;
   logic [STAGES:0]   vld_pipe;
   logic [LEN_W-1:0]  rd_idx_q, rd_idx_nxt;
   logic [LEN_W-1:0]  wr_idx_q;
   logic [LEN_W-1:0]  sat_cnt_q;
   logic [ADDR_W-1:0] rd_addr_a_q, rd_addr_b_q;
   logic [ADDR_W-1:0] wr_addr_q;
   logic [DATA_W-1:0] wr_data_q;

   logic              kill;       // abort while a job is in flight
   logic              start_any;  // start accepted (any length)
   logic              start_run;  // start accepted with work to do
   logic              last_rd;    // current issue slot is element len-1
   logic              rd_next;    // a read is issued next cycle
   logic              busy_c, done_c;

   logic [DATA_W:0]   sum_full;
   logic              ovf;
   logic [DATA_W-1:0] res;

   assign kill       = bus.abort && (state_q != IDLE);
   assign start_any  = (state_q == IDLE) && bus.start;
   assign start_run  = start_any && (bus.len != '0);
   assign rd_idx_nxt = rd_idx_q + LEN_W'(1);
   assign last_rd    = (rd_idx_q == (cfg_q.len - LEN_W'(1)));

   // Sign-extended sum; overflow when the extension bit and the MSB disagree,
   // which is exactly "equal operand signs, different result sign".
   assign sum_full = {bus.rd_data_a[DATA_W-1], bus.rd_data_a}
                   + {bus.rd_data_b[DATA_W-1], bus.rd_data_b};
   assign ovf      = sum_full[DATA_W] ^ sum_full[DATA_W-1];
   assign res      = !ovf             ? sum_full[DATA_W-1:0] :
                     sum_full[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} :
                                        {1'b0, {(DATA_W-1){1'b1}}};

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // FSM next state, read-issue decision and status outputs
   always_comb begin
      state_d = state_q;
      rd_next = 1'b0;
      busy_c  = 1'b1;
      done_c  = 1'b0;
      unique case (state_q)
         IDLE: begin
            busy_c = 1'b0;
            if (bus.start) begin
               if (bus.len == '0) begin
                  state_d = FIN;
               end else begin
                  state_d = ISSUE;
                  rd_next = 1'b1;
               end
            end
         end
         ISSUE: begin
            if (bus.abort)    state_d = IDLE;
            else if (last_rd) state_d = DRAIN;
            else              rd_next = 1'b1;
         end
         DRAIN: begin
            // leave once the last element sits in the write stage
            if (bus.abort)                          state_d = IDLE;
            else if (vld_pipe[STAGES-1:0] == '0)    state_d = FIN;
         end
         FIN: begin
            done_c  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Latch the job configuration; later input changes do not reach the job
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)         cfg_q <= '0;
      else if (start_run) cfg_q <= '{src_a: bus.src_a_base, src_b: bus.src_b_base,
                                     dst: bus.dst_base, len: bus.len};
   end

   // Read address generation; addresses hold when no read is issued
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_idx_q    <= '0;
         rd_addr_a_q <= '0;
         rd_addr_b_q <= '0;
      end else if (start_run) begin
         rd_idx_q    <= '0;
         rd_addr_a_q <= bus.src_a_base;
         rd_addr_b_q <= bus.src_b_base;
      end else if (rd_next) begin
         rd_idx_q    <= rd_idx_nxt;
         rd_addr_a_q <= cfg_q.src_a + ADDR_W'(rd_idx_nxt);
         rd_addr_b_q <= cfg_q.src_b + ADDR_W'(rd_idx_nxt);
      end
   end

   // Valid shift register; abort flushes every stage
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)    vld_pipe <= '0;
      else if (kill) vld_pipe <= '0;
      else           vld_pipe <= {vld_pipe[STAGES-1:0], rd_next};
   end

   // Result stage: register the saturated sum with its destination address
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_idx_q  <= '0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
      end else if (start_run) begin
         wr_idx_q  <= '0;
      end else if (vld_pipe[1] && !kill) begin
         wr_idx_q  <= wr_idx_q + LEN_W'(1);
         wr_addr_q <= cfg_q.dst + ADDR_W'(wr_idx_q);
         wr_data_q <= res;
      end
   end

   // Saturation counter: cleared per job, sticks at all-ones
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         sat_cnt_q <= '0;
      else if (start_any)
         sat_cnt_q <= '0;
      else if (vld_pipe[1] && !kill && ovf && (sat_cnt_q != '1))
         sat_cnt_q <= sat_cnt_q + LEN_W'(1);
   end

   assign bus.rd_en     = vld_pipe[0];
   assign bus.rd_addr_a = rd_addr_a_q;
   assign bus.rd_addr_b = rd_addr_b_q;
   assign bus.wr_en     = vld_pipe[STAGES];
   assign bus.wr_addr   = wr_addr_q;
   assign bus.wr_data   = wr_data_q;
   assign bus.busy      = busy_c;
   assign bus.done      = done_c;
   assign bus.sat_cnt   = sat_cnt_q;

endmodule

// File: tb/tb_vec_add_seq.sv
// Directed bench for vec_add_seq: table-driven jobs against a two-port
// scratchpad model, plus hand sequences for len=0, start-while-busy, abort
// and mid-job reset.
module tb_vec_add_seq;
   localparam int DW = 16;
   localparam int AW = 10;
   localparam int LW = 11;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   cyc   = 0;
   int   n_pass = 0;
   int   n_chk  = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   vec_add_seq_if #(.DATA_W(DW), .ADDR_W(AW), .LEN_W(LW)) bus ();

   vec_add_seq #(.DATA_W(DW), .ADDR_W(AW), .LEN_W(LW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // scratchpad model: registered read, data valid one cycle after rd_en
   logic [DW-1:0] mem_a [1<<AW];
   logic [DW-1:0] mem_b [1<<AW];
   always @(posedge clk) begin
      if (bus.rd_en) begin
         bus.rd_data_a <= mem_a[bus.rd_addr_a];
         bus.rd_data_b <= mem_b[bus.rd_addr_b];
      end
   end

   // bus monitor, sampled on the falling edge
   int            rd_cyc_q[$], wr_cyc_q[$], done_q[$];
   logic [AW-1:0] rda_q[$], rdb_q[$], wra_q[$];
   logic [DW-1:0] wrd_q[$];
   int            busy_n = 0;
   always @(negedge clk) begin
      if (bus.rd_en) begin
         rd_cyc_q.push_back(cyc);
         rda_q.push_back(bus.rd_addr_a);
         rdb_q.push_back(bus.rd_addr_b);
      end
      if (bus.wr_en) begin
         wr_cyc_q.push_back(cyc);
         wra_q.push_back(bus.wr_addr);
         wrd_q.push_back(bus.wr_data);
      end
      if (bus.done) done_q.push_back(cyc);
      if (bus.busy) busy_n++;
   end

   typedef struct { logic [DW-1:0] a, b, exp; } vec_t;
   typedef struct { logic [AW-1:0] sa, sb, dst; int first, len, sat; } job_t;
   vec_t tbl [11];
   job_t jobs [3];
   int   acc_cyc;

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
   endtask

   task automatic clr();
      rd_cyc_q.delete(); wr_cyc_q.delete(); done_q.delete();
      rda_q.delete(); rdb_q.delete(); wra_q.delete(); wrd_q.delete();
      busy_n = 0;
   endtask

   // one-cycle start pulse; inputs are scrambled right after acceptance
   task automatic start_job(input logic [AW-1:0] sa, sb, dst, input logic [LW-1:0] n);
      @(posedge clk); #1;
      clr();
      bus.src_a_base = sa;
      bus.src_b_base = sb;
      bus.dst_base   = dst;
      bus.len        = n;
      bus.start      = 1'b1;
      @(posedge clk); #1;
      acc_cyc        = cyc;
      bus.start      = 1'b0;
      bus.abort      = 1'b0;
      bus.src_a_base = ~sa;
      bus.src_b_base = ~sb;
      bus.dst_base   = ~dst;
      bus.len        = n + LW'(7);
   endtask

   // wait for busy to drop; optionally pulse start at cycle inj
   task automatic wait_idle(input string nm, input int budget, input int inj);
      int n = 0;
      while (bus.busy && n < budget) begin
         @(posedge clk); #1;
         n++;
         bus.start = (cyc == inj);
      end
      bus.start = 1'b0;
      chk(nm, int'(!bus.busy), 1);
   endtask

   task automatic run_job(input int j, input bit drain_start);
      job_t          jb;
      logic [AW-1:0] ea;
      jb = jobs[j];
      for (int k = 0; k < jb.len; k++) begin
         ea = jb.sa + AW'(k); mem_a[ea] = tbl[jb.first+k].a;
         ea = jb.sb + AW'(k); mem_b[ea] = tbl[jb.first+k].b;
      end
      start_job(jb.sa, jb.sb, jb.dst, LW'(jb.len));
      wait_idle($sformatf("job%0d_idle", j), 64, drain_start ? acc_cyc + jb.len : -1);
      chk($sformatf("job%0d_rd_count", j), rd_cyc_q.size(), jb.len);
      chk($sformatf("job%0d_wr_count", j), wr_cyc_q.size(), jb.len);
      chk($sformatf("job%0d_done_count", j), done_q.size(), 1);
      chk($sformatf("job%0d_sat_cnt", j), int'(bus.sat_cnt), jb.sat);
      if (rd_cyc_q.size() == jb.len && wr_cyc_q.size() == jb.len) begin
         chk($sformatf("job%0d_first_rd", j), rd_cyc_q[0] - acc_cyc, 0);
         chk($sformatf("job%0d_wr_lat", j), wr_cyc_q[0] - rd_cyc_q[0], 2);
         for (int k = 0; k < jb.len; k++) begin
            ea = jb.sa + AW'(k);
            chk($sformatf("job%0d_rd_addr_a[%0d]", j, k), int'(rda_q[k]), int'(ea));
            ea = jb.sb + AW'(k);
            chk($sformatf("job%0d_rd_addr_b[%0d]", j, k), int'(rdb_q[k]), int'(ea));
            ea = jb.dst + AW'(k);
            chk($sformatf("job%0d_wr_addr[%0d]", j, k), int'(wra_q[k]), int'(ea));
            chk($sformatf("job%0d_wr_data[%0d]", j, k), int'(wrd_q[k]), int'(tbl[jb.first+k].exp));
            chk($sformatf("job%0d_wr_cyc[%0d]", j, k), wr_cyc_q[k] - wr_cyc_q[0], k);
         end
         if (done_q.size() == 1)
            chk($sformatf("job%0d_done_lat", j), done_q[0] - wr_cyc_q[jb.len-1], 1);
      end
   endtask

   initial begin
      bus.start = 1'b0; bus.abort = 1'b0; bus.len = '0;
      bus.src_a_base = '0; bus.src_b_base = '0; bus.dst_base = '0;
      for (int i = 0; i < (1<<AW); i++) begin
         mem_a[i] = '0;
         mem_b[i] = '0;
      end

      // basic mix, saturation corners, wrap/boundary mix
      tbl[0]  = '{16'h0001, 16'h0001, 16'h0002};
      tbl[1]  = '{16'h0002, 16'h0005, 16'h0007};
      tbl[2]  = '{16'hFFFD, 16'h0003, 16'h0000};
      tbl[3]  = '{16'h0064, 16'hFF38, 16'hFF9C};
      tbl[4]  = '{16'h7FFF, 16'h0001, 16'h7FFF};
      tbl[5]  = '{16'h8000, 16'hFFFF, 16'h8000};
      tbl[6]  = '{16'h4000, 16'h4000, 16'h7FFF};
      tbl[7]  = '{16'h8000, 16'h8000, 16'h8000};
      tbl[8]  = '{16'h7FFF, 16'h7FFF, 16'h7FFF};
      tbl[9]  = '{16'h7FFF, 16'h8000, 16'hFFFF};
      tbl[10] = '{16'hC000, 16'hC000, 16'h8000};
      jobs[0] = '{10'h010, 10'h100, 10'h200, 0, 4, 0};
      jobs[1] = '{10'h020, 10'h120, 10'h220, 4, 3, 3};
      jobs[2] = '{10'h3FE, 10'h130, 10'h3FD, 7, 4, 2};

      // reset state
      repeat (3) @(negedge clk);
      chk("rst_rd_en",   int'(bus.rd_en),   0);
      chk("rst_wr_en",   int'(bus.wr_en),   0);
      chk("rst_busy",    int'(bus.busy),    0);
      chk("rst_done",    int'(bus.done),    0);
      chk("rst_sat_cnt", int'(bus.sat_cnt), 0);
      chk("rst_addrs",   int'(bus.rd_addr_a | bus.rd_addr_b | bus.wr_addr), 0);
      chk("rst_wr_data", int'(bus.wr_data), 0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      for (int j = 0; j < 3; j++) run_job(j, 1'b0);

      // len=0: straight to FIN, no traffic, sat_cnt cleared
      start_job(10'h111, 10'h222, 10'h333, '0);
      wait_idle("len0_idle", 8, -1);
      chk("len0_rd_count", rd_cyc_q.size(), 0);
      chk("len0_wr_count", wr_cyc_q.size(), 0);
      chk("len0_done_count", done_q.size(), 1);
      if (done_q.size() == 1) chk("len0_done_lat", done_q[0] - acc_cyc, 0);
      chk("len0_busy_cycles", busy_n, 1);
      chk("len0_sat_cnt", int'(bus.sat_cnt), 0);

      // start with a different len during DRAIN is ignored
      run_job(1, 1'b1);

      // abort on the 3rd ISSUE cycle of a len=8 job of saturating elements
      for (int k = 0; k < 8; k++) begin
         mem_a[10'h080 + k] = 16'h7FFF;
         mem_b[10'h180 + k] = 16'h0001;
      end
      start_job(10'h080, 10'h180, 10'h280, LW'(8));
      @(posedge clk); #1;
      @(posedge clk); #1;
      bus.abort = 1'b1;
      @(posedge clk); #1;
      bus.abort = 1'b0;
      chk("abort_idle_next", int'(bus.busy), 0);
      chk("abort_rd_en_off", int'(bus.rd_en), 0);
      repeat (12) @(posedge clk); #1;
      chk("abort_wr_le2", int'(wr_cyc_q.size() <= 2), 1);
      chk("abort_rd_le3", int'(rd_cyc_q.size() <= 3), 1);
      chk("abort_no_done", done_q.size(), 0);
      chk("abort_sat_hold", int'(bus.sat_cnt), wr_cyc_q.size());

      // abort idles harmlessly, and start in the same cycle wins
      bus.abort = 1'b1;
      run_job(0, 1'b0);

      // reset mid-job: immediate clear, no writes afterwards
      start_job(10'h080, 10'h180, 10'h280, LW'(8));
      repeat (3) @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      chk("mrst_busy",      int'(bus.busy),      0);
      chk("mrst_rd_en",     int'(bus.rd_en),     0);
      chk("mrst_rd_addr_a", int'(bus.rd_addr_a), 0);
      chk("mrst_wr_data",   int'(bus.wr_data),   0);
      chk("mrst_sat_cnt",   int'(bus.sat_cnt),   0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      clr();
      repeat (12) @(posedge clk); #1;
      chk("mrst_no_wr",   wr_cyc_q.size(), 0);
      chk("mrst_no_rd",   rd_cyc_q.size(), 0);
      chk("mrst_no_busy", busy_n, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/vec_add_seq.md
VEC_ADD_SEQ -- requirements
Module: vec_add_seq

Interface
REQ-001 Parameter DATA_W, default 16: operand and result width, two's complement signed.
REQ-002 Parameter ADDR_W, default 10: scratchpad word-address width.
REQ-003 Parameter LEN_W, default 11: element-count width.
REQ-004 clk  in  1  clock, all state on rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 start  in  1  launch request; sampled only in IDLE.
REQ-007 abort  in  1  synchronous cancel of the current job.
REQ-008 src_a_base, src_b_base, dst_base  in  ADDR_W each  base addresses; latched on an accepted start.
REQ-009 len  in  LEN_W  element count; latched on an accepted start.
REQ-010 rd_en  out  1  read strobe to both operand ports.
REQ-011 rd_addr_a, rd_addr_b  out  ADDR_W each  read addresses.
REQ-012 rd_data_a, rd_data_b  in  DATA_W each  read data, valid exactly 1 cycle after rd_en.
REQ-013 wr_en  out  1  result write strobe.
REQ-014 wr_addr  out  ADDR_W  result address.
REQ-015 wr_data  out  DATA_W  saturated sum.
REQ-016 busy  out  1  high in every state other than IDLE.
REQ-017 done  out  1  single-cycle completion pulse.
REQ-018 sat_cnt  out  LEN_W  number of saturated results in the current or last job.

Function
REQ-019 FSM states: IDLE, ISSUE, DRAIN, FIN.
REQ-020 IDLE with start=1 and len!=0: latch the configuration, clear sat_cnt, and go to ISSUE.
REQ-021 IDLE with start=1 and len=0: clear sat_cnt, go to FIN, and issue no reads or writes.
REQ-022 ISSUE: assert rd_en every cycle with rd_addr_a=src_a_base+i and rd_addr_b=src_b_base+i, for i=0..len-1.
REQ-023 ISSUE: after issuing i=len-1, go to DRAIN.
REQ-024 Pipeline: read data is registered with a valid bit 1 cycle after rd_en.
REQ-025 Pipeline: the sum is registered into wr_data/wr_en 2 cycles after rd_en, with wr_addr=dst_base+i.
REQ-026 Throughput is 1 element per cycle, with no bubbles.
REQ-027 DRAIN: stay until the last write (element len-1) has been emitted, then go to FIN.
REQ-028 FIN: assert done for exactly 1 cycle, then go to IDLE, with busy low from that cycle on.
REQ-029 Arithmetic: a full-width sum is computed.
REQ-030 Saturation: if both operands have equal sign and the sum sign differs, the result is clamped.
REQ-031 Clamp values: positive overflow gives 2^(DATA_W-1)-1 (0x7FFF); negative overflow gives -2^(DATA_W-1) (0x8000).
REQ-032 Otherwise wr_data is the wrapped DATA_W sum.
REQ-033 sat_cnt increments on each clamped written result and holds at all-ones; no wrap.
REQ-034 Addresses wrap modulo 2^ADDR_W without error.
REQ-035 start while busy is ignored; latched configuration stays unchanged.
REQ-036 abort in any non-IDLE state: next cycle state=IDLE.
REQ-037 abort also forces rd_en=0, wr_en=0 and all pipeline valid bits cleared.
REQ-038 After abort: no done pulse and sat_cnt holds its value.
REQ-039 abort in IDLE has no effect.
REQ-040 abort and start in the same IDLE cycle: start is accepted.
REQ-041 Base/len input changes after acceptance do not affect the running job.
REQ-042 rd_addr_* and wr_addr/wr_data hold their last values when the strobes are low.

Reset
REQ-043 rst_n low: state=IDLE and all strobes 0 (rd_en, wr_en, busy, done).
REQ-044 rst_n low: sat_cnt, all address outputs, wr_data and latched configuration set to 0; pipeline valids 0.
REQ-045 Reset asserted mid-job terminates the job immediately; no further writes after deassertion.

Verification
REQ-046 len=4, A={1,2,-3,100}, B={1,5,3,-200}: writes {2,7,0,-100} at dst..dst+3 on 4 consecutive cycles; first wr_en 2 cycles after first rd_en; done 1 cycle after last write; sat_cnt=0.
REQ-047 A={0x7FFF,0x8000,0x4000}, B={0x0001,0xFFFF,0x4000}: results {0x7FFF,0x8000,0x7FFF}; sat_cnt=3.
REQ-048 len=0 with start: no rd_en/wr_en; done 1 cycle after start; busy high for exactly that 1 cycle.
REQ-049 abort asserted on the 3rd ISSUE cycle of len=8: at most 2 writes follow; no done; IDLE next cycle; a new start then runs correctly.
REQ-050 start pulsed during DRAIN with different len: ignored; original job completes.
REQ-051 src_a_base=0x3FE, len=3 (ADDR_W=10): rd_addr_a sequence 0x3FE, 0x3FF, 0x000.
